sdp_ram_byte_wr: RTL



---
 rtl/sdp_ram_byte_wr_if.sv | 34 +++
 rtl/sdp_ram_byte_wr.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/sdp_ram_byte_wr_if.sv
`default_nettype none
// ============================================================================
// Module   : sdp_ram_byte_wr_if
// Purpose  : Bus bundle for sdp_ram_byte_wr (write port A, read port B, status)
// Revision : 1.0
// ============================================================================
interface sdp_ram_byte_wr_if #(
  parameter int LEN_DATA = 32,
  parameter int RAM_SIZE = 4096
);
  localparam int LEN_ADDR = $clog2(RAM_SIZE);
  localparam int NUM_BYTE = LEN_DATA / 8;

  logic                init_busy;
  logic                ena;
  logic [NUM_BYTE-1:0] wea;
  logic [LEN_ADDR-1:0] addra;
  logic [LEN_DATA-1:0] dina;
  logic                enb;
  logic [LEN_ADDR-1:0] addrb;
  logic [LEN_DATA-1:0] doutb;
  logic                doutb_valid;

  modport master (
    output ena, wea, addra, dina, enb, addrb,
    input  init_busy, doutb, doutb_valid
  );

  modport slave (
    input  ena, wea, addra, dina, enb, addrb,
    output init_busy, doutb, doutb_valid
  );
endinterface
`default_nettype wire

// File: rtl/sdp_ram_byte_wr.sv
`default_nettype none
// ============================================================================
// Module   : sdp_ram_byte_wr
// Purpose  : Simple dual-port RAM, byte-strobed writes, write-first collision
//            merge, post-reset clear sequencer. Define SDP_RAM_OUT_REG_EN for
//            an extra output register stage (read latency 2).
// Revision : 1.0
// ============================================================================
module sdp_ram_byte_wr #(
  parameter int LEN_DATA = 32,
  parameter int RAM_SIZE = 4096
) (
  input  wire logic          clk,
  input  wire logic          resetn,
  sdp_ram_byte_wr_if.slave   bus
);
  localparam int LEN_ADDR = $clog2(RAM_SIZE);
  localparam int NUM_BYTE = LEN_DATA / 8;

  localparam logic [0:0]          c_ST_INIT  = 1'b0;
  localparam logic [0:0]          c_ST_READY = 1'b1;
  localparam logic [LEN_ADDR-1:0] c_CNT_LAST = LEN_ADDR'(RAM_SIZE - 1);
  localparam logic [LEN_ADDR:0]   c_SIZE_EXT = (LEN_ADDR + 1)'(RAM_SIZE);

  logic [LEN_DATA-1:0] mem_q [RAM_SIZE];

  logic [0:0]          state_q, state_d;
  logic [LEN_ADDR-1:0] cnt_q, cnt_d;
  logic [LEN_DATA-1:0] doutb_q, doutb_d;
  logic                doutb_valid_q;

  logic                w_ready;
  logic                w_addra_ok;
  logic                w_rd_fire;
  logic [NUM_BYTE-1:0] w_wr_en;
  logic [LEN_ADDR-1:0] w_wr_addr;
  logic [LEN_DATA-1:0] w_wr_data;
  logic [LEN_DATA-1:0] w_rd_word;
  logic [LEN_DATA-1:0] w_rd_merged;

  assign w_ready   = (state_q == c_ST_READY);
  assign w_rd_fire = w_ready & bus.enb;

  // Out-of-range write addresses only exist for non power-of-two depths.
  generate
    if (RAM_SIZE == (1 << LEN_ADDR)) begin : g_pow2
      assign w_addra_ok = 1'b1;
    end else begin : g_npow2
      assign w_addra_ok = ({1'b0, bus.addra} < c_SIZE_EXT);
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == c_ST_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == c_CNT_LAST) begin
        state_d = c_ST_READY;
      end
    end
  end

  // Single write port shared by the clear sequencer and user port A.
  always_comb begin
    w_wr_en   = '0;
    w_wr_addr = bus.addra;
    w_wr_data = bus.dina;
    if (!w_ready) begin
      w_wr_en   = '1;
      w_wr_addr = cnt_q;
      w_wr_data = '0;
    end else if (bus.ena && w_addra_ok) begin
      w_wr_en   = bus.wea;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_BYTE; i++) begin
      if (w_wr_en[i]) begin
        mem_q[w_wr_addr][8*i +: 8] <= w_wr_data[8*i +: 8];
      end
    end
  end

  assign w_rd_word = mem_q[bus.addrb];

  // Write-first: strobed bytes of a same-address write bypass the array.
  always_comb begin
    w_rd_merged = w_rd_word;
    for (int i = 0; i < NUM_BYTE; i++) begin
      if (bus.ena && bus.wea[i] && (bus.addra == bus.addrb)) begin
        w_rd_merged[8*i +: 8] = bus.dina[8*i +: 8];
      end
    end
  end

  always_comb begin
    doutb_d = doutb_q;
    if (w_rd_fire) begin
      doutb_d = w_rd_merged;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= c_ST_INIT;
      cnt_q         <= '0;
      doutb_q       <= '0;
      doutb_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      doutb_q       <= doutb_d;
      doutb_valid_q <= w_rd_fire;
    end
  end

  assign bus.init_busy = ~w_ready;

`ifdef SDP_RAM_OUT_REG_EN
  logic [LEN_DATA-1:0] dout2_q, dout2_d;
  logic                dout2_valid_q;

  always_comb begin
    dout2_d = dout2_q;
    if (doutb_valid_q) begin
      dout2_d = doutb_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      dout2_q       <= '0;
      dout2_valid_q <= 1'b0;
    end else begin
      dout2_q       <= dout2_d;
      dout2_valid_q <= doutb_valid_q;
    end
  end

  assign bus.doutb       = dout2_q;
  assign bus.doutb_valid = dout2_valid_q;
`else
  assign bus.doutb       = doutb_q;
  assign bus.doutb_valid = doutb_valid_q;
`endif

endmodule
`default_nettype wire
